// File: rtl/reaction_timer.sv
// reaction_timer: ms up/down timer with ms tick, zero flag and preload (random when TIMER_RANDOM_DELAY_EN)
module reaction_timer #(
  parameter int MAX_MS       = 2047,
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 500,
  parameter int RAND_MASK    = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      timer_reset,
  input  logic                      up,
  input  logic                      enable,
  output logic [$clog2(MAX_MS)-1:0] timer_value,
  output logic                      ms_tick,
  output logic                      at_zero
);
  localparam int W  = $clog2(MAX_MS);
  localparam int PW = $clog2(CLKS_PER_MS);
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  value_q, value_d, preload;
  logic          ms_tick_q, ms_tick_d, at_zero_q, at_zero_d, tick;
`ifdef TIMER_RANDOM_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    preload = W'(MIN_DELAY_MS) + W'(lfsr_q & 16'(RAND_MASK));
  end
  always_ff @(posedge clk) lfsr_q <= rst ? 16'hACE1 : lfsr_d;
`else
  always_comb preload = W'(MIN_DELAY_MS);
`endif
  always_comb begin
    tick      = enable && !timer_reset && presc_q == PW'(CLKS_PER_MS - 1);
    presc_d   = (timer_reset || tick) ? PW'(0) : enable ? presc_q + PW'(1) : presc_q;
    value_d   = timer_reset ? (up ? W'(0) : preload)
              : !tick       ? value_q
              : up          ? (value_q == W'(0) ? value_q : value_q - W'(1))
              :               (value_q == W'(MAX_MS) ? value_q : value_q + W'(1));
    ms_tick_d = tick;
    at_zero_d = value_d == W'(0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      value_q   <= '0;
      ms_tick_q <= 1'b0;
      at_zero_q <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      value_q   <= value_d;
      ms_tick_q <= ms_tick_d;
      at_zero_q <= at_zero_d;
    end
  end
  assign timer_value = value_q;
  assign ms_tick     = ms_tick_q;
  assign at_zero     = at_zero_q;
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: scoreboard bench for reaction_timer (CLKS_PER_MS=4, MIN_DELAY_MS=3)
module tb_reaction_timer;
  logic clk = 1'b0, rst = 1'b1, timer_reset = 1'b0, up = 1'b0, enable = 1'b0;
  logic [10:0] timer_value;
  logic ms_tick, at_zero;
  int cyc = 0, n_checks = 0, n_pass = 0, c, r, ld;
  typedef struct {int v; int c;} exp_t;
  exp_t q[$];
  reaction_timer #(.MAX_MS(2047), .CLKS_PER_MS(4), .MIN_DELAY_MS(3), .RAND_MASK(1023)) dut (
    .clk(clk), .rst(rst), .timer_reset(timer_reset), .up(up), .enable(enable),
    .timer_value(timer_value), .ms_tick(ms_tick), .at_zero(at_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int v, input int cy);
    q.push_back('{v, cy});
  endtask
  task automatic drain(input string name);
    enable = 1'b0;
    @(negedge clk);
    #1;
    check(name, q.size(), 0);
    step(1);
  endtask
  task automatic clr();
    timer_reset = 1'b1;
    up = 1'b1;
    step(1);
    timer_reset = 1'b0;
    check("clr_value", int'(timer_value), 0);
  endtask
  always @(negedge clk) begin
    if (ms_tick === 1'b1) begin
      exp_t e;
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL tick_unexpected: cycle %0d value %0d, no tick expected", cyc, timer_value);
      end else begin
        e = q.pop_front();
        if (int'(timer_value) == e.v && at_zero == (e.v == 0) && cyc == e.c) n_pass++;
        else $display("FAIL tick: got value %0d at_zero %0b cycle %0d, expected value %0d at_zero %0b cycle %0d",
                      timer_value, at_zero, cyc, e.v, e.v == 0, e.c);
      end
    end
  end
  initial begin
    step(2);
    rst = 1'b0;
    check("rst_value", int'(timer_value), 0);
    check("rst_at_zero", int'(at_zero), 1);
    check("rst_ms_tick", int'(ms_tick), 0);
    step(1);
    check("idle_at_zero", int'(at_zero), 1);
    timer_reset = 1'b1;
    up = 1'b0;
    step(1);
    timer_reset = 1'b0;
`ifdef TIMER_RANDOM_DELAY_EN
    ld = 3 + ('h59C3 & 1023);
`else
    ld = 3;
`endif
    check("load_value", int'(timer_value), ld);
    check("load_at_zero", int'(at_zero), 0);
    up = 1'b1;
    enable = 1'b1;
    c = cyc;
    for (int n = 1; n <= ld + 5; n++) push(n <= ld ? ld - n : 0, c + 4 * n);
    step(4 * (ld + 5));
    drain("down_drain");
    clr();
    check("clr_at_zero", int'(at_zero), 1);
    up = 1'b0;
    enable = 1'b1;
    c = cyc;
    for (int n = 1; n <= 2050; n++) push(n < 2047 ? n : 2047, c + 4 * n);
    step(8200);
    check("sat_value", int'(timer_value), 2047);
    drain("up_drain");
    clr();
    up = 1'b0;
    enable = 1'b1;
    c = cyc;
    push(1, c + 9);
    push(2, c + 13);
    push(1, c + 17);
    push(0, c + 21);
    push(0, c + 25);
    step(2);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(6);
    up = 1'b1;
    step(12);
    drain("pause_drain");
    clr();
    up = 1'b0;
    enable = 1'b1;
    c = cyc;
    push(1, c + 4);
    push(2, c + 8);
    step(11);
    timer_reset = 1'b1;
    up = 1'b1;
    step(1);
    timer_reset = 1'b0;
    check("prio_value", int'(timer_value), 0);
    check("prio_at_zero", int'(at_zero), 1);
    check("prio_ms_tick", int'(ms_tick), 0);
    drain("prio_drain");
    clr();
    up = 1'b0;
    enable = 1'b1;
    c = cyc;
    for (int n = 1; n <= 100; n++) push(n, c + 4 * n);
    step(402);
    check("pre_rst_value", int'(timer_value), 100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_value", int'(timer_value), 0);
    check("mid_rst_at_zero", int'(at_zero), 1);
    check("mid_rst_ms_tick", int'(ms_tick), 0);
    r = cyc;
    push(1, r + 4);
    step(4);
    drain("rst_drain");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
